// File: rtl/stream_zero_pad_if.sv
// Handshake bundle for stream_zero_pad: frame configuration, input row stream,
// padded output row stream and frame completion pulse.
//
// Optional macro ZPAD_PAD_VALUE_EN adds cfg_pad_value (pad element value).
//
// Modports:
//   master - producer/consumer side (drives cfg_*, in_*, out_ready)
//   slave  - the padding stage itself
//
// Signals:
//   cfg_valid/cfg_ready     frame configuration handshake
//   cfg_pad_top/bottom      zero rows before/after the body
//   cfg_pad_left            pad lanes inserted on the lane-0 side
//   cfg_cols                valid input lanes per row, 0 means LANES
//   cfg_rows                body rows taken from the input
//   in_valid/in_ready/in_data     input row stream (lane 0 in the MSBs)
//   out_valid/out_ready/out_data  padded output row stream
//   out_last                final row of the frame
//   frame_done              one-cycle completion pulse
interface stream_zero_pad_if #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned PAD_W  = 5,
    parameter int unsigned ROW_W  = 16
);
    localparam int unsigned DATA_W = LANES * ELEM_W;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [PAD_W-1:0]  cfg_pad_top;
    logic [PAD_W-1:0]  cfg_pad_bottom;
    logic [PAD_W-1:0]  cfg_pad_left;
    logic [PAD_W-1:0]  cfg_cols;
    logic [ROW_W-1:0]  cfg_rows;
`ifdef ZPAD_PAD_VALUE_EN
    logic [ELEM_W-1:0] cfg_pad_value;
`endif
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              frame_done;

    modport master (
`ifdef ZPAD_PAD_VALUE_EN
        output cfg_pad_value,
`endif
        output cfg_valid, cfg_pad_top, cfg_pad_bottom, cfg_pad_left, cfg_cols, cfg_rows,
        output in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data, out_last, frame_done
    );

    modport slave (
`ifdef ZPAD_PAD_VALUE_EN
        input  cfg_pad_value,
`endif
        input  cfg_valid, cfg_pad_top, cfg_pad_bottom, cfg_pad_left, cfg_cols, cfg_rows,
        input  in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_data, out_last, frame_done
    );
endinterface

// File: rtl/stream_zero_pad.sv
// Streaming 2-D zero-padding stage between the unified buffer read port and the
// systolic array row feeder. Per frame: pad_top pad rows, cfg_rows body rows
// (left-shifted by pad_left, masked to cols lanes), then pad_bottom pad rows.
// Output is registered; one row per cycle when out_ready stays high.
//
// Optional macro ZPAD_PAD_VALUE_EN: pad value comes from cfg_pad_value
// (latched with the config) instead of constant 0.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - stream_zero_pad_if slave modport (cfg, in and out streams, frame_done)
module stream_zero_pad #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned PAD_W  = 5,
    parameter int unsigned ROW_W  = 16
) (
    input logic               clk,
    input logic               rst,
    stream_zero_pad_if.slave  bus
);
    localparam int unsigned DATA_W = LANES * ELEM_W;

    typedef enum logic [2:0] {StIdle, StTop, StBody, StBottom, StDone} state_e;

    state_e            r_state, w_state_nxt;
    logic [PAD_W-1:0]  r_top, r_bottom, r_left, r_cols;
    logic [ROW_W-1:0]  r_rows;
    logic [ROW_W-1:0]  r_row_cnt, w_cnt_nxt;
    logic              r_out_valid, w_valid_nxt;
    logic [DATA_W-1:0] r_out_data, w_data_nxt;
    logic              r_out_last, w_last_nxt;
    logic              r_frame_done, w_done_nxt;

    logic              w_cfg_accept;
    logic              w_cfg_ready;
    logic              w_in_ready;
    logic              w_adv;
    logic              w_cnt_last;
    logic [ROW_W-1:0]  w_limit;
    state_e            w_first_phase, w_after_top, w_after_body;
    logic [ELEM_W-1:0] w_pad_val;
    logic [DATA_W-1:0] w_pad_row, w_shifted, w_body_row;
    logic [PAD_W:0]    w_cols_eff, w_win_end;

`ifdef ZPAD_PAD_VALUE_EN
    logic [ELEM_W-1:0] r_pad_val;
    assign w_pad_val = r_pad_val;
`else
    assign w_pad_val = '0;
`endif

    assign w_adv        = !r_out_valid || bus.out_ready;
    assign w_cfg_accept = (r_state == StIdle) && bus.cfg_valid;
    assign w_pad_row    = {LANES{w_pad_val}};

    // Phase ordering: skip every phase whose count is zero.
    assign w_first_phase = (bus.cfg_pad_top != '0)    ? StTop    :
                           (bus.cfg_rows != '0)       ? StBody   :
                           (bus.cfg_pad_bottom != '0) ? StBottom : StDone;
    assign w_after_top   = (r_rows != '0)   ? StBody   :
                           (r_bottom != '0) ? StBottom : StDone;
    assign w_after_body  = (r_bottom != '0) ? StBottom : StDone;

    always_comb begin
        case (r_state)
            StTop:    w_limit = ROW_W'(r_top);
            StBody:   w_limit = r_rows;
            StBottom: w_limit = ROW_W'(r_bottom);
            default:  w_limit = '0;
        endcase
    end
    assign w_cnt_last = (r_row_cnt == w_limit - ROW_W'(1));

    // Lane 0 sits in the MSBs, so a right shift moves lanes toward higher
    // indices; lanes pushed past LANES-1 fall off, pad_left >= LANES gives 0.
    assign w_cols_eff = (r_cols == '0) ? (PAD_W + 1)'(LANES) : {1'b0, r_cols};
    assign w_win_end  = {1'b0, r_left} + w_cols_eff;
    assign w_shifted  = bus.in_data >> (r_left * ELEM_W);

    always_comb begin
        w_body_row = w_shifted;
        for (int j = 0; j < LANES; j++) begin
            if (((PAD_W + 1)'(j) < {1'b0, r_left}) || ((PAD_W + 1)'(j) >= w_win_end)) begin
                w_body_row[DATA_W-1-j*ELEM_W -: ELEM_W] = w_pad_val;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_row_cnt;
        w_valid_nxt = r_out_valid && !bus.out_ready;
        w_data_nxt  = r_out_data;
        w_last_nxt  = w_valid_nxt ? r_out_last : 1'b0;
        w_done_nxt  = 1'b0;
        w_cfg_ready = 1'b0;
        w_in_ready  = 1'b0;
        case (r_state)
            StIdle: begin
                w_cfg_ready = 1'b1;
                if (bus.cfg_valid) begin
                    w_state_nxt = w_first_phase;
                    w_cnt_nxt   = '0;
                end
            end
            StTop, StBottom: begin
                if (w_adv) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_pad_row;
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = r_row_cnt + ROW_W'(1);
                    if (w_cnt_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_state == StTop) ? w_after_top : StDone;
                        w_last_nxt  = (r_state == StBottom) || (w_after_top == StDone);
                    end
                end
            end
            StBody: begin
                w_in_ready = w_adv;
                if (w_adv && bus.in_valid) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_body_row;
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = r_row_cnt + ROW_W'(1);
                    if (w_cnt_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = w_after_body;
                        w_last_nxt  = (w_after_body == StDone);
                    end
                end
            end
            StDone: begin
                // Last row already loaded; finish once it has drained.
                if (w_adv) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_row_cnt    <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_top        <= '0;
            r_bottom     <= '0;
            r_left       <= '0;
            r_cols       <= '0;
            r_rows       <= '0;
`ifdef ZPAD_PAD_VALUE_EN
            r_pad_val    <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_row_cnt    <= w_cnt_nxt;
            r_out_valid  <= w_valid_nxt;
            r_out_data   <= w_data_nxt;
            r_out_last   <= w_last_nxt;
            r_frame_done <= w_done_nxt;
            if (w_cfg_accept) begin
                r_top    <= bus.cfg_pad_top;
                r_bottom <= bus.cfg_pad_bottom;
                r_left   <= bus.cfg_pad_left;
                r_cols   <= bus.cfg_cols;
                r_rows   <= bus.cfg_rows;
`ifdef ZPAD_PAD_VALUE_EN
                r_pad_val <= bus.cfg_pad_value;
`endif
            end
        end
    end

    assign bus.cfg_ready  = w_cfg_ready;
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_last   = r_out_last;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_stream_zero_pad.sv
// Self-checking bench for stream_zero_pad: scoreboard of expected output rows
// filled as stimulus is driven, compared by a monitor on each output handshake.
`timescale 1ns/1ps
module tb_stream_zero_pad;
    localparam int LANES  = 16;
    localparam int ELEM_W = 8;
    localparam int PAD_W  = 5;
    localparam int ROW_W  = 16;
    localparam int DATA_W = LANES * ELEM_W;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_zero_pad_if #(.LANES(LANES), .ELEM_W(ELEM_W), .PAD_W(PAD_W), .ROW_W(ROW_W)) bus ();

    stream_zero_pad #(.LANES(LANES), .ELEM_W(ELEM_W), .PAD_W(PAD_W), .ROW_W(ROW_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard monitor: every output handshake pops one expected row.
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.out_valid && bus.out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_row: got %h last=%b, required no row", bus.out_data,
                         bus.out_last);
            end else begin
                e = sb_q.pop_front();
                if (bus.out_data !== e.data || bus.out_last !== e.last) begin
                    bad++;
                    $display("FAIL out_row: got %h last=%b, required %h last=%b", bus.out_data,
                             bus.out_last, e.data, e.last);
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] model_row(input logic [DATA_W-1:0] d, input int left,
                                                    input int cols, input logic [7:0] pv);
        logic [DATA_W-1:0] r;
        int ce;
        int src;
        ce = (cols == 0) ? LANES : cols;
        for (int j = 0; j < LANES; j++) begin
            src = j - left;
            if (src >= 0 && src < ce) r[DATA_W-1-j*ELEM_W -: ELEM_W] = d[DATA_W-1-src*ELEM_W -: ELEM_W];
            else r[DATA_W-1-j*ELEM_W -: ELEM_W] = pv;
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_exp(input logic last, input logic [DATA_W-1:0] d);
        exp_t e;
        e.last = last;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic send_cfg(input int top, input int bottom, input int left, input int cols,
                            input int rows);
        int n;
        n = 0;
        bus.cfg_pad_top    = PAD_W'(top);
        bus.cfg_pad_bottom = PAD_W'(bottom);
        bus.cfg_pad_left   = PAD_W'(left);
        bus.cfg_cols       = PAD_W'(cols);
        bus.cfg_rows       = ROW_W'(rows);
        bus.cfg_valid      = 1'b1;
        while (!bus.cfg_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (!bus.cfg_ready) begin
            bad++;
            $display("FAIL cfg_timeout: cfg_ready=%b required 1", bus.cfg_ready);
        end
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
    endtask

    // Leaves in_valid high so callers can stream rows back to back.
    task automatic send_row(input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (!bus.in_ready) begin
            bad++;
            $display("FAIL in_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_frame_done(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (bus.frame_done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 5;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
        if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %b required 0", bus.out_last); end
        if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b required 0", bus.frame_done); end
        if (bus.out_data !== '0) begin bad++; $display("FAIL rst_out_data: got %h required 0", bus.out_data); end
        if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_cfg_ready: got %b required 1", bus.cfg_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_basic_pad();
        logic [DATA_W-1:0] d, e;
        bit found;
        d = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
        e = 128'h0000_0102_0300_0000_0000_0000_0000_0000;
        bus.out_ready = 1'b1;
        push_exp(1'b0, '0);
        push_exp(1'b0, e);
        push_exp(1'b0, e);
        push_exp(1'b1, '0);
        send_cfg(1, 1, 2, 3, 2);
        send_row(d);
        send_row(d);
        bus.in_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_last) found = 1'b1;
        end
        total += 5;
        if (!found) begin bad++; $display("FAIL basic_last_seen: got 0 required 1"); end
        if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL basic_done_early: got %b required 0", bus.frame_done); end
        @(negedge clk);
        if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL basic_done_pulse: got %b required 1", bus.frame_done); end
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_drained: got %b required 0", bus.out_valid); end
        @(negedge clk);
        if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b required 0", bus.frame_done); end
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL basic_sb_empty: got %0d required 0", sb_q.size()); end
    endtask

    task automatic test_passthrough();
        logic [DATA_W-1:0] r;
        int last_cyc;
        bit seen;
        bus.out_ready = 1'b1;
        send_cfg(0, 0, 0, 0, 3);
        last_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            r = rand_row();
            push_exp(k == 2, r);
            send_row(r);
            total += 2;
            if (bus.out_valid !== 1'b1 || bus.out_data !== r) begin
                bad++;
                $display("FAIL pass_latency: got v=%b %h required v=1 %h", bus.out_valid, bus.out_data, r);
            end
            if (k > 0 && cyc - last_cyc != 1) begin
                bad++;
                $display("FAIL pass_b2b: got gap %0d required 1", cyc - last_cyc);
            end
            last_cyc = cyc;
        end
        bus.in_valid = 1'b0;
        wait_frame_done(seen);
        total++;
        if (!seen) begin bad++; $display("FAIL pass_done: got 0 required 1"); end
    endtask

    task automatic test_left_overflow();
        bit seen;
        bus.out_ready = 1'b1;
        send_cfg(0, 0, 16, 0, 1);
        push_exp(1'b1, '0);
        send_row(rand_row());
        bus.in_valid = 1'b0;
        total += 2;
        if (bus.out_data !== '0 || bus.out_last !== 1'b1) begin
            bad++;
            $display("FAIL left16_row: got %h last=%b required 0 last=1", bus.out_data, bus.out_last);
        end
        wait_frame_done(seen);
        if (!seen) begin bad++; $display("FAIL left16_done: got 0 required 1"); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] r1, r2;
        bit seen;
        r1 = rand_row();
        r2 = rand_row();
        bus.out_ready = 1'b0;
        send_cfg(0, 0, 0, 0, 2);
        push_exp(1'b0, r1);
        push_exp(1'b1, r2);
        send_row(r1);
        bus.in_data = r2;
        for (int k = 0; k < 3; k++) begin
            total += 2;
            if (bus.out_valid !== 1'b1 || bus.out_data !== r1) begin
                bad++;
                $display("FAIL bp_hold: got v=%b %h required v=1 %h", bus.out_valid, bus.out_data, r1);
            end
            if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b required 0", bus.in_ready); end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        total += 2;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got %b required 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (bus.out_data !== r2) begin bad++; $display("FAIL bp_next_row: got %h required %h", bus.out_data, r2); end
        wait_frame_done(seen);
        total++;
        if (!seen) begin bad++; $display("FAIL bp_done: got 0 required 1"); end
    endtask

    task automatic test_mid_frame_reset();
        logic [DATA_W-1:0] d;
        bit seen;
        bus.out_ready = 1'b1;
        send_cfg(0, 0, 0, 0, 5);
        send_row(rand_row());
        bus.in_data = rand_row();
        rst = 1'b0;
        @(posedge clk); #1;
        total += 3;
        if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL mrst_idle: got %b required 1", bus.cfg_ready); end
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid: got %b required 0", bus.out_valid); end
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mrst_in_ready: got %b required 0", bus.in_ready); end
        sb_q.delete();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        d = rand_row();
        send_cfg(0, 1, 1, 4, 1);
        push_exp(1'b0, model_row(d, 1, 4, 8'h00));
        push_exp(1'b1, '0);
        send_row(d);
        bus.in_valid = 1'b0;
        wait_frame_done(seen);
        total += 2;
        if (!seen) begin bad++; $display("FAIL mrst_new_done: got 0 required 1"); end
        if (sb_q.size() != 0) begin bad++; $display("FAIL mrst_sb_empty: got %0d required 0", sb_q.size()); end
    endtask

    task automatic test_empty_frame();
        send_cfg(0, 0, 0, 0, 0);
        @(negedge clk);
        total += 3;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL empty_no_row: got %b required 0", bus.out_valid); end
        @(negedge clk);
        if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL empty_done: got %b required 1", bus.frame_done); end
        if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL empty_idle: got %b required 1", bus.cfg_ready); end
    endtask

    task automatic test_random_cfg();
        int top, bottom, left, cols, rows;
        logic [DATA_W-1:0] d;
        bit seen;
        bus.out_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            top    = $urandom_range(0, 2);
            bottom = $urandom_range(0, 2);
            left   = $urandom_range(0, 16);
            cols   = $urandom_range(0, 16);
            rows   = $urandom_range(1, 3);
            for (int k = 0; k < top; k++) push_exp(1'b0, '0);
            send_cfg(top, bottom, left, cols, rows);
            for (int k = 0; k < rows; k++) begin
                d = rand_row();
                push_exp((k == rows - 1) && (bottom == 0), model_row(d, left, cols, 8'h00));
                send_row(d);
            end
            bus.in_valid = 1'b0;
            for (int k = 0; k < bottom; k++) push_exp(k == bottom - 1, '0);
            wait_frame_done(seen);
            total += 2;
            if (!seen) begin bad++; $display("FAIL rand_done: frame %0d got 0 required 1", f); end
            if (sb_q.size() != 0) begin bad++; $display("FAIL rand_sb_empty: got %0d required 0", sb_q.size()); end
        end
    endtask

`ifdef ZPAD_PAD_VALUE_EN
    task automatic test_pad_value();
        logic [DATA_W-1:0] d;
        bit seen;
        d = rand_row();
        bus.out_ready     = 1'b1;
        bus.cfg_pad_value = 8'hAA;
        push_exp(1'b0, {LANES{8'hAA}});
        push_exp(1'b1, {8'hAA, d[DATA_W-1:ELEM_W]});
        send_cfg(1, 0, 1, 15, 1);
        send_row(d);
        bus.in_valid = 1'b0;
        wait_frame_done(seen);
        total += 2;
        if (!seen) begin bad++; $display("FAIL padval_done: got 0 required 1"); end
        if (sb_q.size() != 0) begin bad++; $display("FAIL padval_sb_empty: got %0d required 0", sb_q.size()); end
        bus.cfg_pad_value = 8'h00;
    endtask
`endif

    initial begin
        bus.cfg_valid      = 1'b0;
        bus.cfg_pad_top    = '0;
        bus.cfg_pad_bottom = '0;
        bus.cfg_pad_left   = '0;
        bus.cfg_cols       = '0;
        bus.cfg_rows       = '0;
`ifdef ZPAD_PAD_VALUE_EN
        bus.cfg_pad_value  = '0;
`endif
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        bus.out_ready      = 1'b0;
        test_reset();
        test_basic_pad();
        test_passthrough();
        test_left_overflow();
        test_backpressure();
        test_mid_frame_reset();
        test_empty_frame();
        test_random_cfg();
`ifdef ZPAD_PAD_VALUE_EN
        test_pad_value();
`endif
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stream_zero_pad.md
Name: stream_zero_pad

Overview:
- Streaming 2-D zero-padding stage between the unified buffer read port and the systolic array row feeder.
- Each accepted row word of LANES elements gets left padding and column-count masking.
- A per-frame state machine inserts pad_top zero rows before the body rows and pad_bottom zero rows after them.
- Valid/ready handshakes on input and output; the output is registered.

Parameters:
- LANES, 16, elements per row word.
- ELEM_W, 8, bits per element; DATA_W = LANES*ELEM_W.
- PAD_W, 5, width of the pad and column fields; holds values 0..LANES.
- ROW_W, 16, width of the row-count field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  frame configuration offered.
- cfg_ready  out  1  high only in IDLE.
- cfg_pad_top  in  PAD_W  zero rows emitted before the body.
- cfg_pad_bottom  in  PAD_W  zero rows emitted after the body.
- cfg_pad_left  in  PAD_W  zero lanes inserted at lane 0 side.
- cfg_cols  in  PAD_W  valid input lanes per row; 0 means LANES.
- cfg_rows  in  ROW_W  body rows consumed from the input.
- in_valid  in  1  input row valid.
- in_ready  out  1  input row accepted when high together with in_valid.
- in_data  in  DATA_W  input row; lane 0 = bits [DATA_W-1 -: ELEM_W].
- out_valid  out  1  output row valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  padded row.
- out_last  out  1  final row of the frame.
- frame_done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; out_valid, out_last, frame_done, out_data and counters all 0. Applies mid-frame; any in-flight row is discarded.
- States: IDLE, TOP, BODY, BOTTOM, DONE.
- Config: the cfg handshake in IDLE latches all cfg fields. Next state is the first phase with a nonzero count, in order TOP(pad_top), BODY(rows), BOTTOM(pad_bottom), else DONE.
- Slot free: adv = !out_valid || out_ready.
- TOP/BOTTOM:
  - On adv, load out_data with the pad row and set out_valid.
  - row_cnt increments; at count-1 go to the next nonzero phase.
  - in_ready=0.
- BODY:
  - in_ready = adv.
  - On the in handshake, the registered row appears on the next cycle (latency 1).
  - Output lane j = in lane (j-pad_left) when pad_left <= j < pad_left+cols_eff, else pad value.
  - Lanes shifted beyond LANES-1 are dropped.
  - pad_left >= LANES yields an all-pad row.
- out_last is set with the row whose emission ends the last nonzero phase.
- DONE:
  - Entered after that last row is loaded.
  - Waits until out_valid==0 or the out handshake of the last row occurs, then pulses frame_done and returns to IDLE.
  - An all-zero config pulses frame_done one cycle after accept with no rows emitted.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable and no counter advances.
- Throughput: one row per cycle when out_ready is held high.
- cfg_valid outside IDLE is ignored (cfg_ready=0).
- in_valid outside BODY is ignored.

Optional Feature:
- Macro ZPAD_PAD_VALUE_EN.
- Defined: adds port cfg_pad_value (in, ELEM_W), latched with the config. Every pad lane and every pad row element is filled with this value.
- Undefined: the port is absent and the pad value is constant 0.

Test Plan:
- LANES=16, ELEM_W=8. Config top=1, bottom=1, left=2, cols=3, rows=2; in rows 128'h0102_0304_..._0F10 twice, out_ready=1. Required response:
  - 4 rows out: zero row, then 128'h0000_0102_0300_0000_0000_0000_0000_0000 twice, then a zero row.
  - out_last on row 4; frame_done the cycle after its handshake.
- Config left=0, cols=0, rows=3, top=bottom=0 -> the 3 rows pass unchanged, each 1 cycle after acceptance, back-to-back.
- Config left=16, rows=1 -> output 128'h0 with out_last=1.
- Body row held with out_ready=0 for 3 cycles -> out_data stable, in_ready=0, and the next row is accepted the cycle after out_ready rises.
- rst=0 during BODY row 2 of 5 -> next cycle: IDLE, out_valid=0, cfg_ready=1; a new frame then runs correctly.
- ZPAD_PAD_VALUE_EN with pad_value=8'hAA, top=1, left=1, cols=15, rows=1 -> first row all 8'hAA, second row = AA followed by in lanes 0..14.
